conv_acc_stream: RTL
====================

// Module: conv_acc_stream
// PURPOSE
//  Upstream producer for the normalisation/ReLU stage. Accepts a stream of signed
//  activation/weight pairs with valid/ready, MAC-accumulates one dot product per output
//  (terminated by in_last), then presents conv_val with that channel's scale/offset.
//  Per-channel scale/offset come from a small register table loaded over a config port.
// PARAMETERS
//  ACT_W      8   activation width (signed)
//  WGT_W      8   weight width (signed)
//  IN_W       22  accumulator / conv_val width (signed); must be >= ACT_W+WGT_W
//  SCALE_W    8   per-channel scale width (signed)
//  OFFSET_W   8   per-channel offset width (signed)
//  N_CH       16  channel table depth; CH_W = $clog2(N_CH)
//  MAX_TERMS  256 dot-product length limit; TERM_W = $clog2(MAX_TERMS+1)
// PORTS
//  clk         in   1         clock
//  rst_n       in   1         async active-low reset
//  in_valid    in   1         input beat valid
//  in_ready    out  1         input beat accepted when in_valid & in_ready
//  in_act      in   ACT_W     signed activation
//  in_wgt      in   WGT_W     signed weight
//  in_last     in   1         beat is the last term of the current dot product
//  in_ch       in   CH_W      output channel; sampled on the last beat only
//  cfg_we      in   1         table write strobe
//  cfg_addr    in   CH_W      table write address
//  cfg_scale   in   SCALE_W   scale to write
//  cfg_offset  in   OFFSET_W  offset to write
//  out_valid   out  1         result valid
//  out_ready   in   1         downstream accept
//  conv_val    out  IN_W      signed dot-product result
//  scale       out  SCALE_W   scale for the result's channel
//  offset      out  OFFSET_W  offset for the result's channel
//  err_ovf     out  1         sticky: accumulator overflow occurred
//  err_len     out  1         sticky: dot product exceeded MAX_TERMS
// BEHAVIOUR
//  - Reset (async assert, sync deassert): acc=0, term_cnt=0, out_valid=0, conv_val=0,
//    scale=0, offset=0, err_ovf=0, err_len=0, table entries all 0.
//  - in_ready = !out_valid | out_ready (one-entry output register, no bubble on accept).
//  - Accepted beat: p = in_act*in_wgt (ACT_W+WGT_W bits, sign-extended to IN_W);
//    acc_next = acc + p; term_cnt++.
//  - Accepted beat with in_last: next cycle out_valid=1, conv_val=acc_next, scale/offset =
//    table[in_ch]; acc and term_cnt return to 0 the same edge. Latency 1 cycle last->valid.
//  - out_valid holds with stable data until out_valid & out_ready. Accept and a new last
//    beat on the same edge: output reloads with the new result, out_valid stays 1.
//  - State: IDLE (term_cnt=0) -> ACC on non-last beat; ACC -> IDLE on last beat.
//    Single-term dot product (last on first beat) goes IDLE->IDLE with a result.
//  - term_cnt reaching MAX_TERMS without in_last: err_len set; the MAX_TERMS-th beat is
//    treated as last (result emitted, acc cleared).
//  - Overflow: signed sum of acc and p not representable in IN_W sets err_ovf (sticky).
//  - Table write: table[cfg_addr] <= {cfg_scale,cfg_offset} on cfg_we. Write and last-beat
//    lookup to the same address in the same cycle: new (written) value is output.
//  - in_ch out of range (>= N_CH when N_CH not a power of 2): scale=0, offset=0.
//  - Sticky errors clear only on reset.
// CONFIGURATION
//  CONV_ACC_SAT_EN defined: on overflow acc saturates to +2^(IN_W-1)-1 or -2^(IN_W-1) and
//   stays clamped for remaining terms of that dot product; err_ovf still set.
//  Not defined: acc wraps modulo 2^IN_W; err_ovf still set.
// TESTING
//  - Reset mid-accumulation (3 beats in), rst_n low -> all outputs 0, next dot product clean.
//  - Beats (3,4),(-2,5),(7,7)last, ch=2 with table[2]={8'sd5,-8'sd3} -> conv_val=51,
//    scale=5, offset=-3, out_valid one cycle after last beat.
//  - out_ready=0 for 4 cycles after result -> in_ready=0, conv_val stable; release -> accept.
//  - Back-to-back single-term products (last every beat, out_ready=1) -> one result/cycle.
//  - 200 beats of (127,127): +3,225,800 > 2^21-1 -> err_ovf=1; with CONV_ACC_SAT_EN
//    conv_val=2097151, without conv_val wraps (3225800-4194304 = -968504).
//  - MAX_TERMS=4, 4 beats no last -> result after 4th, err_len=1; cfg_we same-cycle
//    same-channel as last beat -> new scale/offset on output.

Source files
------------

// File: rtl/conv_acc_stream.sv
// rtl/conv_acc_stream.sv - streaming MAC dot-product accumulator with per-channel scale/offset table (optional CONV_ACC_SAT_EN)
module conv_acc_stream #(
    parameter  int ACT_W     = 8,
    parameter  int WGT_W     = 8,
    parameter  int IN_W      = 22,
    parameter  int SCALE_W   = 8,
    parameter  int OFFSET_W  = 8,
    parameter  int N_CH      = 16,
    parameter  int MAX_TERMS = 256,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int TERM_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [ACT_W-1:0]    in_act,
    input  logic signed [WGT_W-1:0]    in_wgt,
    input  logic                       in_last,
    input  logic [CH_W-1:0]            in_ch,
    input  logic                       cfg_we,
    input  logic [CH_W-1:0]            cfg_addr,
    input  logic signed [SCALE_W-1:0]  cfg_scale,
    input  logic signed [OFFSET_W-1:0] cfg_offset,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [IN_W-1:0]     conv_val,
    output logic signed [SCALE_W-1:0]  scale,
    output logic signed [OFFSET_W-1:0] offset,
    output logic                       err_ovf,
    output logic                       err_len
);

    localparam int P_W = ACT_W + WGT_W;
    localparam logic signed [IN_W-1:0] ACC_MAX = {1'b0, {(IN_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] ACC_MIN = {1'b1, {(IN_W-1){1'b0}}};

    typedef enum logic {IDLE, ACC} state_t;

    state_t                      state, state_next;
    logic signed [IN_W-1:0]      acc;
    logic signed [IN_W-1:0]      acc_next;
    logic [TERM_W-1:0]           term_cnt;
    logic [TERM_W-1:0]           cnt_inc;
    logic signed [P_W-1:0]       prod;
    logic signed [IN_W:0]        acc_x;
    logic signed [IN_W:0]        prod_x;
    logic signed [IN_W:0]        sum;
    logic                        ovf;
    logic                        ovf_hit;
    logic                        at_max;
    logic                        last_eff;
    logic                        accept;
    logic signed [SCALE_W-1:0]   lk_scale;
    logic signed [OFFSET_W-1:0]  lk_offset;
    logic signed [SCALE_W-1:0]   tbl_scale  [N_CH];
    logic signed [OFFSET_W-1:0]  tbl_offset [N_CH];

    // Single-entry output register: a new beat may enter whenever the slot frees this edge
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // One extra guard bit on the sum exposes signed overflow as a top-two-bit mismatch
    assign prod    = in_act * in_wgt;
    assign acc_x   = acc;
    assign prod_x  = prod;
    assign sum     = acc_x + prod_x;
    assign ovf     = sum[IN_W] ^ sum[IN_W-1];
    assign cnt_inc = term_cnt + 1'b1;
    // A dot product that hits the length limit is force-terminated on that beat
    assign at_max   = (cnt_inc == TERM_W'(MAX_TERMS));
    assign last_eff = in_last || at_max;

`ifdef CONV_ACC_SAT_EN
    logic sat_hold;

    // Clamp on overflow and freeze the clamped value for the rest of the dot product
    always_comb begin
        acc_next = sum[IN_W-1:0];
        ovf_hit  = ovf && !sat_hold;
        if (sat_hold) begin
            acc_next = acc;
        end else if (ovf) begin
            acc_next = sum[IN_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Remember that the current dot product has saturated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_hold <= 1'b0;
        end else if (accept) begin
            sat_hold <= last_eff ? 1'b0 : (sat_hold || ovf);
        end
    end
`else
    // Wrap-around accumulation modulo 2^IN_W
    always_comb begin
        acc_next = sum[IN_W-1:0];
        ovf_hit  = ovf;
    end
`endif

    // Channel lookup; a same-cycle config write to the looked-up channel bypasses the table
    always_comb begin
        lk_scale  = '0;
        lk_offset = '0;
        if (32'(in_ch) < N_CH) begin
            if (cfg_we && (cfg_addr == in_ch)) begin
                lk_scale  = cfg_scale;
                lk_offset = cfg_offset;
            end else begin
                lk_scale  = tbl_scale[in_ch];
                lk_offset = tbl_offset[in_ch];
            end
        end
    end

    // Per-channel scale/offset table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                tbl_scale[i]  <= '0;
                tbl_offset[i] <= '0;
            end
        end else if (cfg_we && (32'(cfg_addr) < N_CH)) begin
            tbl_scale[cfg_addr]  <= cfg_scale;
            tbl_offset[cfg_addr] <= cfg_offset;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: any non-terminating beat moves into ACC, a terminating beat returns to IDLE
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = last_eff ? IDLE : ACC;
        end
    end

    // Accumulator and term counter; both clear on the terminating beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            term_cnt <= '0;
        end else if (accept) begin
            if (last_eff) begin
                acc      <= '0;
                term_cnt <= '0;
            end else begin
                acc      <= acc_next;
                term_cnt <= cnt_inc;
            end
        end
    end

    // Output register: load on terminating beat, otherwise drop valid once accepted downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            conv_val  <= '0;
            scale     <= '0;
            offset    <= '0;
        end else if (accept && last_eff) begin
            out_valid <= 1'b1;
            conv_val  <= acc_next;
            scale     <= lk_scale;
            offset    <= lk_offset;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
            err_len <= 1'b0;
        end else if (accept) begin
            err_ovf <= err_ovf || ovf_hit;
            err_len <= err_len || (at_max && !in_last);
        end
    end

endmodule
